dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single data-memory port (address_dmem/data/wren/q_dmem) between two requesters.
  - Port P: the processor load/store path.
  - Port L: a loader/debug master that preloads or inspects dmem.
- Arbitrates each cycle, steers the winner onto dmem, and tracks outstanding reads so read data returns to the correct requester after the fixed memory latency.
- Sits between the processor core and the dmem instance at top level.

Parameters:
- ADDR_W, 12, dmem word-address width.
- DATA_W, 32, dmem data width.
- RD_LAT, 1, cycles from an accepted read to q_dmem being valid (legal range 1..4).
- MAX_WAIT, 4, consecutive cycles L may be refused while requesting before it is forced to win (legal range 1..15).

Ports:
- clock  in  1  master clock, all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- p_req  in  1  processor requests an access this cycle.
- p_wren  in  1  1 = write, 0 = read (qualified by p_req).
- p_addr  in  ADDR_W  processor address.
- p_data  in  DATA_W  processor write data.
- p_gnt  out  1  processor access accepted this cycle (combinational).
- p_rvalid  out  1  p_q valid; single-cycle pulse.
- p_q  out  DATA_W  read data to processor (mirrors q_dmem).
- l_req  in  1  loader requests an access.
- l_wren  in  1  loader write enable.
- l_addr  in  ADDR_W  loader address.
- l_data  in  DATA_W  loader write data.
- l_gnt  out  1  loader access accepted this cycle (combinational).
- l_rvalid  out  1  l_q valid; single-cycle pulse.
- l_q  out  DATA_W  read data to loader (mirrors q_dmem).
- address_dmem  out  ADDR_W  to dmem.
- data  out  DATA_W  write data to dmem.
- wren  out  1  dmem write enable.
- q_dmem  in  DATA_W  dmem read data.

Behaviour:
- Handshake: an access is accepted in any cycle where req && gnt.
  - A requester refused a grant must hold req/wren/addr/data stable until granted.
  - Dropping req before grant is allowed; the request is then lost.
- At most one gnt is high per cycle; gnt is never high without the matching req.
- Dmem steering (combinational):
  - Granted requester's addr/data/wren drive address_dmem/data/wren.
  - With no grant: address_dmem = 0, data = 0, wren = 0.
- Default arbitration is processor priority with a starvation guard:
  - Only one requesting: that requester wins.
  - Both requesting and wait_cnt < MAX_WAIT: P wins, and wait_cnt increments (saturating at 15).
  - Both requesting and wait_cnt == MAX_WAIT: L wins.
  - wait_cnt clears to 0 on every cycle L is granted, and on any cycle with l_req = 0.
- Read return:
  - Tag pipeline RD_LAT deep of {valid, owner}; an accepted read inserts {1, owner}, anything else inserts {0, x}.
  - The tag leaving the pipeline asserts p_rvalid or l_rvalid for exactly one cycle.
  - Throughput is one access per cycle; back-to-back reads from either or mixed requesters return in issue order.
- Writes produce no rvalid. A write followed by a read of the same address in the next cycle returns the new data; this is a dmem property, and the arbiter adds no reordering.
- Reset (synchronous):
  - gnt, rvalid, wren = 0; address_dmem and data = 0.
  - wait_cnt = 0; tag pipeline cleared; round-robin pointer (if compiled in) = "P next".
- Reset mid-operation: reads still in flight are discarded and no rvalid is issued for them. Requests sampled during reset are not granted.
- p_q and l_q always equal q_dmem; consumers qualify with rvalid.

Optional Feature:
- Macro: DMEM_ARB_RR_EN.
- Defined: arbitration is strict round-robin.
  - One-bit pointer names the preferred requester.
  - On contention the preferred requester wins, and the pointer flips to the other requester after every grant.
  - wait_cnt and MAX_WAIT are unused; the logic is removed.
- Undefined: processor priority with the MAX_WAIT starvation guard, as described above.

Test Plan:
- Reset, then P read addr 0x010 only (dmem preloaded 0x010 = 0xDEADBEEF) -> p_gnt same cycle, address_dmem = 0x010, wren = 0; p_rvalid pulses RD_LAT cycles later with p_q = 0xDEADBEEF; l_rvalid stays 0.
- L write 0x020 <- 0x12345678, then L read 0x020 next cycle -> wren = 1 on the first cycle only; l_rvalid after RD_LAT with l_q = 0x12345678.
- Both requesters hold req high continuously with MAX_WAIT = 4, default build -> grant sequence P,P,P,P,L repeating; wait_cnt never exceeds 4.
- Same stimulus with DMEM_ARB_RR_EN defined -> grants alternate P,L,P,L starting with P after reset.
- Interleaved reads P 0x001, L 0x002, P 0x003 on consecutive cycles with RD_LAT = 2 -> rvalids arrive in the same order on the correct ports, each one cycle apart with the correct data.
- Issue P read, assert reset in the next cycle for one cycle -> no p_rvalid ever appears; all outputs are 0 during reset; a fresh request after reset is granted normally.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-requester (processor P, loader L) arbiter for the single dmem port; round-robin when DMEM_ARB_RR_EN is defined.
// Latency: grant and steering are combinational; read data returns RD_LAT cycles after acceptance, tagged by owner.
// Backpressure: a refused requester holds its request; L is forced to win after MAX_WAIT refusals (priority mode).
module dmem_arbiter #(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 32,
  parameter int RD_LAT   = 1,
  parameter int MAX_WAIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              p_req,
  input  logic              p_wren,
  input  logic [ADDR_W-1:0] p_addr,
  input  logic [DATA_W-1:0] p_data,
  output logic              p_gnt,
  output logic              p_rvalid,
  output logic [DATA_W-1:0] p_q,
  input  logic              l_req,
  input  logic              l_wren,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_data,
  output logic              l_gnt,
  output logic              l_rvalid,
  output logic [DATA_W-1:0] l_q,
  output logic [ADDR_W-1:0] address_dmem,
  output logic [DATA_W-1:0] data,
  output logic              wren,
  input  logic [DATA_W-1:0] q_dmem
);

  logic p_win;
  logic l_win;

`ifdef DMEM_ARB_RR_EN
  // rr_ptr: 0 = P preferred, 1 = L preferred
  logic rr_ptr;

  always_comb begin
    p_win = 1'b0;
    l_win = 1'b0;
    if (!reset) begin
      if (p_req && l_req) begin
        p_win = !rr_ptr;
        l_win = rr_ptr;
      end else begin
        p_win = p_req;
        l_win = l_req;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr <= 1'b0;
    end else if (p_win) begin
      rr_ptr <= 1'b1;
    end else if (l_win) begin
      rr_ptr <= 1'b0;
    end
  end
`else
  localparam logic [3:0] WAIT_LIM = 4'(MAX_WAIT);

  logic [3:0] wait_cnt;

  always_comb begin
    p_win = 1'b0;
    l_win = 1'b0;
    if (!reset) begin
      l_win = l_req && (!p_req || (wait_cnt >= WAIT_LIM));
      p_win = p_req && !l_win;
    end
  end

  // Counts consecutive contention losses of L; any cycle L is idle or served resets it.
  always_ff @(posedge clock) begin
    if (reset) begin
      wait_cnt <= 4'd0;
    end else if (!l_req || l_win) begin
      wait_cnt <= 4'd0;
    end else if (wait_cnt != 4'hF) begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end
`endif

  assign p_gnt = p_win;
  assign l_gnt = l_win;

  always_comb begin
    address_dmem = '0;
    data         = '0;
    wren         = 1'b0;
    if (p_win) begin
      address_dmem = p_addr;
      data         = p_data;
      wren         = p_wren;
    end else if (l_win) begin
      address_dmem = l_addr;
      data         = l_data;
      wren         = l_wren;
    end
  end

  logic              rd_acc;
  logic [RD_LAT-1:0] tag_vld;
  logic [RD_LAT-1:0] tag_own;

  assign rd_acc = (p_win && !p_wren) || (l_win && !l_wren);

  // Tag shift register mirrors the dmem read latency; owner 1 = L.
  always_ff @(posedge clock) begin
    if (reset) begin
      tag_vld <= '0;
      tag_own <= '0;
    end else begin
      tag_vld[0] <= rd_acc;
      tag_own[0] <= rd_acc && l_win;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_own[i] <= tag_own[i-1];
      end
    end
  end

  assign p_rvalid = !reset && tag_vld[RD_LAT-1] && !tag_own[RD_LAT-1];
  assign l_rvalid = !reset && tag_vld[RD_LAT-1] &&  tag_own[RD_LAT-1];
  assign p_q      = q_dmem;
  assign l_q      = q_dmem;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural dmem (RD_LAT-deep read pipe); covers both arbitration builds.
module tb_dmem_arbiter;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
  localparam int RD_LAT = 2;

  logic              clock = 1'b0;
  logic              reset;
  logic              p_req, p_wren, l_req, l_wren;
  logic [ADDR_W-1:0] p_addr, l_addr, address_dmem;
  logic [DATA_W-1:0] p_data, l_data, data, q_dmem, p_q, l_q;
  logic              p_gnt, p_rvalid, l_gnt, l_rvalid, wren;

  int errors = 0;
  int checks = 0;

  dmem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .MAX_WAIT(4)
  ) dut (
    .clock(clock), .reset(reset),
    .p_req(p_req), .p_wren(p_wren), .p_addr(p_addr), .p_data(p_data),
    .p_gnt(p_gnt), .p_rvalid(p_rvalid), .p_q(p_q),
    .l_req(l_req), .l_wren(l_wren), .l_addr(l_addr), .l_data(l_data),
    .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_q(l_q),
    .address_dmem(address_dmem), .data(data), .wren(wren), .q_dmem(q_dmem)
  );

  always #5 clock = ~clock;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] qs  [RD_LAT];

  always @(posedge clock) begin
    qs[0] <= mem[address_dmem];
    for (int i = 1; i < RD_LAT; i++) qs[i] <= qs[i-1];
    if (wren) mem[address_dmem] <= data;
  end
  assign q_dmem = qs[RD_LAT-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic pr, input logic pw, input logic [11:0] pa, input logic [31:0] pd,
                       input logic lr, input logic lw, input logic [11:0] la, input logic [31:0] ld);
    p_req = pr; p_wren = pw; p_addr = pa; p_data = pd;
    l_req = lr; l_wren = lw; l_addr = la; l_data = ld;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 1'b0, 12'h000, 32'h0);
  endtask

  task automatic cyc();
    @(negedge clock);
  endtask

  task automatic chk_all_zero(input string tag);
    chk1({tag, "_p_gnt"}, p_gnt, 1'b0);
    chk1({tag, "_l_gnt"}, l_gnt, 1'b0);
    chk1({tag, "_wren"}, wren, 1'b0);
    chk({tag, "_addr"}, {20'h0, address_dmem}, 32'h0);
    chk({tag, "_data"}, data, 32'h0);
    chk1({tag, "_p_rvalid"}, p_rvalid, 1'b0);
    chk1({tag, "_l_rvalid"}, l_rvalid, 1'b0);
  endtask

  logic [11:0] pre_a [4];
  logic [31:0] pre_d [4];
  logic [9:0]  exp_l1;
  logic [7:0]  exp_l2;

  initial begin
    pre_a = '{12'h010, 12'h001, 12'h002, 12'h003};
    pre_d = '{32'hDEADBEEF, 32'h11111111, 32'h22222222, 32'h33333333};
`ifdef DMEM_ARB_RR_EN
    exp_l1 = 10'b1010101010;
    exp_l2 = 8'b10101010;
`else
    exp_l1 = 10'b1000010000;
    exp_l2 = 8'b10000000;
`endif

    // Reset with both requesters active: nothing granted, all outputs zero
    reset = 1'b1;
    idle();
    cyc();
    drive(1'b1, 1'b0, 12'h010, 32'h0, 1'b1, 1'b1, 12'h020, 32'hAA);
    #1 chk_all_zero("rst");
    cyc();
    reset = 1'b0;
    idle();

    // Preload through the loader port
    for (int i = 0; i < 4; i++) begin
      cyc();
      drive(1'b0, 1'b0, 12'h000, 32'h0, 1'b1, 1'b1, pre_a[i], pre_d[i]);
      #1 chk1("pre_l_gnt", l_gnt, 1'b1);
    end

    // P read of 0x010
    cyc();
    drive(1'b1, 1'b0, 12'h010, 32'h0, 1'b0, 1'b0, 12'h000, 32'h0);
    #1;
    chk1("t1_p_gnt", p_gnt, 1'b1);
    chk1("t1_l_gnt", l_gnt, 1'b0);
    chk("t1_addr", {20'h0, address_dmem}, 32'h010);
    chk1("t1_wren", wren, 1'b0);
    cyc(); idle();
    #1 chk1("t1_early_rvalid", p_rvalid, 1'b0);
    cyc();
    #1;
    chk1("t1_p_rvalid", p_rvalid, 1'b1);
    chk("t1_p_q", p_q, 32'hDEADBEEF);
    chk1("t1_l_rvalid", l_rvalid, 1'b0);
    cyc();
    #1 chk1("t1_pulse_end", p_rvalid, 1'b0);

    // L write then L read of the same address
    cyc();
    drive(1'b0, 1'b0, 12'h000, 32'h0, 1'b1, 1'b1, 12'h020, 32'h12345678);
    #1;
    chk1("t2_w_l_gnt", l_gnt, 1'b1);
    chk1("t2_w_wren", wren, 1'b1);
    chk("t2_w_data", data, 32'h12345678);
    chk("t2_w_addr", {20'h0, address_dmem}, 32'h020);
    cyc();
    drive(1'b0, 1'b0, 12'h000, 32'h0, 1'b1, 1'b0, 12'h020, 32'h0);
    #1;
    chk1("t2_r_l_gnt", l_gnt, 1'b1);
    chk1("t2_r_wren", wren, 1'b0);
    cyc(); idle();
    cyc();
    #1;
    chk1("t2_l_rvalid", l_rvalid, 1'b1);
    chk("t2_l_q", l_q, 32'h12345678);
    chk1("t2_p_rvalid", p_rvalid, 1'b0);

    // Contention from a fresh reset
    cyc(); reset = 1'b1;
    cyc(); reset = 1'b0;
    drive(1'b1, 1'b0, 12'h001, 32'h0, 1'b1, 1'b0, 12'h002, 32'h0);
    for (int i = 0; i < 10; i++) begin
      #1;
      chk1("t3_p_gnt", p_gnt, !exp_l1[i]);
      chk1("t3_l_gnt", l_gnt, exp_l1[i]);
      cyc();
    end
    // L drops its request for one cycle, clearing its wait count
    for (int j = 0; j < 8; j++) begin
      drive(1'b1, 1'b0, 12'h001, 32'h0, (j != 2), 1'b0, 12'h002, 32'h0);
      #1;
      chk1("t3b_p_gnt", p_gnt, !exp_l2[j]);
      chk1("t3b_l_gnt", l_gnt, exp_l2[j]);
      cyc();
    end
    idle();
    cyc(); cyc(); cyc();

    // Interleaved reads return in order to the right owners
    drive(1'b1, 1'b0, 12'h001, 32'h0, 1'b0, 1'b0, 12'h000, 32'h0);
    #1 chk1("t4_gnt0", p_gnt, 1'b1);
    cyc();
    drive(1'b0, 1'b0, 12'h000, 32'h0, 1'b1, 1'b0, 12'h002, 32'h0);
    #1 chk1("t4_gnt1", l_gnt, 1'b1);
    cyc();
    drive(1'b1, 1'b0, 12'h003, 32'h0, 1'b0, 1'b0, 12'h000, 32'h0);
    #1;
    chk1("t4_gnt2", p_gnt, 1'b1);
    chk1("t4_rv0_p", p_rvalid, 1'b1);
    chk1("t4_rv0_l", l_rvalid, 1'b0);
    chk("t4_q0", p_q, 32'h11111111);
    cyc(); idle();
    #1;
    chk1("t4_rv1_l", l_rvalid, 1'b1);
    chk1("t4_rv1_p", p_rvalid, 1'b0);
    chk("t4_q1", l_q, 32'h22222222);
    cyc();
    #1;
    chk1("t4_rv2_p", p_rvalid, 1'b1);
    chk1("t4_rv2_l", l_rvalid, 1'b0);
    chk("t4_q2", p_q, 32'h33333333);
    cyc();
    #1;
    chk1("t4_done_p", p_rvalid, 1'b0);
    chk1("t4_done_l", l_rvalid, 1'b0);

    // Reset while a read is in flight
    cyc();
    drive(1'b1, 1'b0, 12'h010, 32'h0, 1'b0, 1'b0, 12'h000, 32'h0);
    #1 chk1("t5_pre_gnt", p_gnt, 1'b1);
    cyc();
    reset = 1'b1;
    drive(1'b1, 1'b0, 12'h003, 32'h0, 1'b1, 1'b1, 12'h004, 32'h55);
    #1 chk_all_zero("t5_rst");
    cyc();
    reset = 1'b0;
    idle();
    #1;
    chk1("t5_no_p_rvalid", p_rvalid, 1'b0);
    chk1("t5_no_l_rvalid", l_rvalid, 1'b0);
    cyc();
    #1 chk1("t5_no_p_rvalid2", p_rvalid, 1'b0);
    cyc();
    drive(1'b1, 1'b0, 12'h010, 32'h0, 1'b0, 1'b0, 12'h000, 32'h0);
    #1;
    chk1("t5_fresh_gnt", p_gnt, 1'b1);
    chk("t5_fresh_addr", {20'h0, address_dmem}, 32'h010);
    cyc(); idle();
    cyc();
    #1;
    chk1("t5_fresh_rvalid", p_rvalid, 1'b1);
    chk("t5_fresh_q", p_q, 32'hDEADBEEF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
